ceas_time_ctrl: RTL

Time-keeping and set-mode controller for the ceas clock design. Owns the hh:mm:ss counters and the one-second prescaler, and sequences time setting from the three front-panel buttons (b1 mode, b2 increment, b3 decrement). Accepts a time-load request from the UART receive path through a valid/ready handshake. Its outputs feed the 7-segment display driver and the status LED.

---
 rtl/ceas_pkg.sv | 30 +++
 rtl/ceas_debounce.sv | 50 +++++
 rtl/ceas_time_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/ceas_pkg.sv
// Shared types and constants for the ceas clock time controller:
// the mode enum, field widths, field limits and a wrap-around step helper.
package ceas_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } mode_t;

  localparam int HH_W = 5;
  localparam int MM_W = 6;
  localparam int SS_W = 6;

  localparam logic [HH_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [MM_W-1:0] MIN_MAX  = 6'd59;

  // Hours step with wrap: up 23->0, down 0->23.
  function automatic logic [HH_W-1:0] hh_step(input logic [HH_W-1:0] v, input logic up);
    if (up) return (v == HOUR_MAX) ? '0 : v + 1'b1;
    return (v == '0) ? HOUR_MAX : v - 1'b1;
  endfunction

  // Minutes/seconds step with wrap: up 59->0, down 0->59.
  function automatic logic [MM_W-1:0] mm_step(input logic [MM_W-1:0] v, input logic up);
    if (up) return (v == MIN_MAX) ? '0 : v + 1'b1;
    return (v == '0) ? MIN_MAX : v - 1'b1;
  endfunction

endpackage

// File: rtl/ceas_debounce.sv
// Button conditioner: 2-flop synchronizer, stable-sample counter, debounced
// level and a one-cycle press pulse on a debounced 0->1 transition.
// The synchronizer and level come out of reset as "pressed", so a button held
// through reset must be released and pressed again before it yields a press;
// a released button simply settles to 0 without producing any event.
module ceas_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1;
  logic          s2;
  logic          level_q;
  logic [CW-1:0] cnt;

  // Synchronize, count consecutive disagreeing samples, then accept the new level.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1      <= 1'b1;
      s2      <= 1'b1;
      level   <= 1'b1;
      level_q <= 1'b1;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      s1      <= btn;
      s2      <= s1;
      level_q <= level;
      press   <= level & ~level_q;
      if (s2 != level) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          level <= s2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ceas_time_ctrl.sv
// Time-keeping and set-mode controller: hh:mm:ss counters, one-second
// prescaler, RUN/SET_HOUR/SET_MIN sequencing from three buttons, and a
// time-load port from the UART path.
// Optional build macro CEAS_AUTOREPEAT_EN adds hold-to-repeat for b2/b3 in
// the set states; without it each press gives exactly one inc/dec.
module ceas_time_ctrl
  import ceas_pkg::*;
#(
  parameter int TICK_CYCLES     = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        b1,
  input  logic        b2,
  input  logic        b3,
  input  logic        load_valid,
  input  logic [4:0]  load_hh,
  input  logic [5:0]  load_mm,
  output logic        load_ready,
  output logic        load_err,
  output logic [4:0]  hours,
  output logic [5:0]  minutes,
  output logic [5:0]  seconds,
  output logic [1:0]  mode,
  output logic        blink,
  output logic        sec_pulse,
  output logic        led
);

  localparam int PW = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_CYCLES / 2);

  mode_t         state;
  mode_t         state_nx;
  logic [PW-1:0] presc;
  logic          p1, p2, p3;
  logic          l1, l2, l3;
  logic          inc_raw, dec_raw;
  logic          ev_inc, ev_dec;
  logic          wrap, xfer, load_ok;
  logic          unused_lvl;

  ceas_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db1 (
    .clock(clock), .reset(reset), .btn(b1), .level(l1), .press(p1));
  ceas_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db2 (
    .clock(clock), .reset(reset), .btn(b2), .level(l2), .press(p2));
  ceas_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db3 (
    .clock(clock), .reset(reset), .btn(b3), .level(l3), .press(p3));

`ifdef CEAS_AUTOREPEAT_EN
  localparam int HOLD_CYCLES = (8 * TICK_CYCLES) / 16;
  localparam int RATE_CYCLES = (TICK_CYCLES / 8 < 1) ? 1 : TICK_CYCLES / 8;
  localparam int RW          = $clog2(HOLD_CYCLES + 1);

  logic          rep_on, rep_dir, rep_first, rep_fire;
  logic [RW-1:0] rep_cnt;

  assign rep_fire = rep_on &&
                    (rep_cnt == (rep_first ? RW'(HOLD_CYCLES - 1) : RW'(RATE_CYCLES - 1)));

  // Hold timer: first repeat after the hold delay, then at the repeat rate;
  // cancelled by release, a mode change, or leaving the set states.
  always_ff @(posedge clock) begin
    if (reset) begin
      rep_on    <= 1'b0;
      rep_dir   <= 1'b0;
      rep_first <= 1'b0;
      rep_cnt   <= '0;
    end else if (p1 || state == RUN) begin
      rep_on <= 1'b0;
    end else if (p2 ^ p3) begin
      rep_on    <= 1'b1;
      rep_dir   <= p3;
      rep_first <= 1'b1;
      rep_cnt   <= '0;
    end else if (rep_on && !(rep_dir ? l3 : l2)) begin
      rep_on <= 1'b0;
    end else if (rep_fire) begin
      rep_cnt   <= '0;
      rep_first <= 1'b0;
    end else if (rep_on) begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end

  assign inc_raw    = p2 | (rep_fire & ~rep_dir);
  assign dec_raw    = p3 | (rep_fire & rep_dir);
  assign unused_lvl = l1;
`else
  assign inc_raw    = p2;
  assign dec_raw    = p3;
  assign unused_lvl = ^{l1, l2, l3};
`endif

  // Mode change beats inc/dec; inc together with dec cancels both.
  assign ev_inc = inc_raw & ~dec_raw & ~p1;
  assign ev_dec = dec_raw & ~inc_raw & ~p1;

  // Load handshake: a transfer happens on any cycle where load_valid and
  // load_ready are both high; ready is offered only in RUN and does not
  // depend on valid. Out-of-range values are consumed but flagged.
  assign load_ready = (state == RUN);
  assign xfer       = load_valid & load_ready;
  assign load_ok    = (load_hh <= HOUR_MAX) && (load_mm <= MIN_MAX);

  assign wrap  = (presc == PRESC_LAST);
  assign mode  = state;
  assign led   = (state != RUN);
  assign blink = (state != RUN) && (presc >= PRESC_HALF);

  // Mode state register.
  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else       state <= state_nx;
  end

  // Next mode: each b1 event advances RUN -> SET_HOUR -> SET_MIN -> RUN.
  always_comb begin
    state_nx = state;
    if (p1) begin
      case (state)
        RUN:      state_nx = SET_HOUR;
        SET_HOUR: state_nx = SET_MIN;
        default:  state_nx = RUN;
      endcase
    end
  end

  // Prescaler, time counters, edits, load and the pulse outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      presc     <= '0;
      hours     <= '0;
      minutes   <= '0;
      seconds   <= '0;
      sec_pulse <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      sec_pulse <= 1'b0;
      load_err  <= 1'b0;
      presc     <= wrap ? '0 : presc + 1'b1;
      case (state)
        RUN: begin
          if (xfer && load_ok) begin
            hours   <= load_hh;
            minutes <= load_mm;
            seconds <= '0;
            presc   <= '0;
          end else begin
            if (xfer) load_err <= 1'b1;
            if (wrap) begin
              sec_pulse <= 1'b1;
              seconds   <= mm_step(seconds, 1'b1);
              if (seconds == MIN_MAX) begin
                minutes <= mm_step(minutes, 1'b1);
                if (minutes == MIN_MAX) hours <= hh_step(hours, 1'b1);
              end
            end
          end
        end
        SET_HOUR: begin
          if (ev_inc)      hours <= hh_step(hours, 1'b1);
          else if (ev_dec) hours <= hh_step(hours, 1'b0);
        end
        SET_MIN: begin
          if (p1) begin
            seconds <= '0;
            presc   <= '0;
          end else if (ev_inc) begin
            minutes <= mm_step(minutes, 1'b1);
          end else if (ev_dec) begin
            minutes <= mm_step(minutes, 1'b0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
